// File: rtl/tilt_motion_tracker.sv
// tilt_motion_tracker: turns 2-bit per-axis tilt codes and a stop flag into a
// debounced, speed-ramped, screen-clamped sprite position. All motion state
// advances only on a divided motion tick; inputs are registered once first.
module tilt_motion_tracker #(
  parameter int TICK_DIV     = 500000,
  parameter int STABLE_TICKS = 3,
  parameter int RAMP_TICKS   = 10,
  parameter int SPEED_MAX    = 8,
  parameter int X_MAX        = 624,
  parameter int Y_MAX        = 464
) (
  input  logic       iCLK,
  input  logic       iRST,
  input  logic [1:0] iDATA_X,
  input  logic [1:0] iDATA_Y,
  input  logic       iSTOP,
  output logic [9:0] oPOS_X,
  output logic [9:0] oPOS_Y,
  output logic [3:0] oSPEED,
  output logic       oMOVING,
  output logic [3:0] oEDGE,
  output logic       oUPDATE
);

  localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int STAB_W = $clog2(STABLE_TICKS + 1);
  localparam int RAMP_W = (RAMP_TICKS > 1) ? $clog2(RAMP_TICKS) : 1;

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [STAB_W-1:0] STAB_FULL = STAB_W'(STABLE_TICKS);
  localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(STABLE_TICKS - 1);
  localparam logic [RAMP_W-1:0] RAMP_LAST = RAMP_W'(RAMP_TICKS - 1);
  localparam logic [3:0]        SPEED_TOP = 4'(SPEED_MAX);
  localparam logic [9:0]        X_LIM     = 10'(X_MAX);
  localparam logic [9:0]        Y_LIM     = 10'(Y_MAX);
  localparam logic [9:0]        X_HOME    = 10'(X_MAX / 2);
  localparam logic [9:0]        Y_HOME    = 10'(Y_MAX / 2);

  typedef enum logic [1:0] {S_IDLE, S_ACCEL, S_CRUISE, S_HALT} state_t;

  state_t              state, state_n;
  logic [3:0]          speed, speed_n;
  logic [RAMP_W-1:0]   ramp, ramp_n;
  logic [TICK_W-1:0]   tick_cnt;
  logic                tick;
  logic                stop_r;
  logic [1:0]          raw  [2];   // index 0 = X axis, 1 = Y axis
  logic [1:0]          cand [2];
  logic [1:0]          filt [2];
  logic [STAB_W-1:0]   scnt [2];
  logic [3:0]          dir, prev_dir;
  logic                active, move;
  logic [9:0]          pos_x, pos_y, pos_x_n, pos_y_n;

  assign tick = (tick_cnt == TICK_LAST);
  assign dir  = {filt[1], filt[0]};

  // One axis step in 11-bit signed arithmetic, clamped to [0, lim].
  function automatic logic [9:0] step_axis(input logic [9:0] pos, input logic [1:0] d,
                                           input logic [3:0] spd, input logic [9:0] lim);
    logic signed [10:0] sum;
    sum = $signed({1'b0, pos});
    if (d == 2'b01)      sum = sum + $signed({7'd0, spd});
    else if (d == 2'b10) sum = sum - $signed({7'd0, spd});
    if (sum[10])                        return 10'd0;
    else if (sum > $signed({1'b0, lim})) return lim;
    else                                return sum[9:0];
  endfunction

  // Input register; the undefined code 11 is folded to level here.
  always_ff @(posedge iCLK) begin
    // NOTE: every registered value uses <= so all flops update from pre-edge
    // values; blocking assignments here would make results order-dependent.
    if (iRST) begin
      raw[0] <= 2'b00;
      raw[1] <= 2'b00;
      stop_r <= 1'b0;
    end else begin
      raw[0] <= (iDATA_X == 2'b11) ? 2'b00 : iDATA_X;
      raw[1] <= (iDATA_Y == 2'b11) ? 2'b00 : iDATA_Y;
      stop_r <= iSTOP;
    end
  end

  // Free-running motion tick divider; phase restarts on reset.
  always_ff @(posedge iCLK) begin
    if (iRST || tick) tick_cnt <= '0;
    else              tick_cnt <= tick_cnt + TICK_W'(1);
  end

  // Per-axis debounce: a new raw code restarts the candidate at once, a code
  // held for STABLE_TICKS ticks becomes the filtered direction.
  always_ff @(posedge iCLK) begin
    for (int a = 0; a < 2; a++) begin
      if (iRST) begin
        cand[a] <= 2'b00;
        scnt[a] <= '0;
        filt[a] <= 2'b00;
      end else if (raw[a] != cand[a]) begin
        cand[a] <= raw[a];
        scnt[a] <= '0;
      end else if (tick) begin
        if (scnt[a] != STAB_FULL) scnt[a] <= scnt[a] + STAB_W'(1);
        if (scnt[a] >= STAB_LAST) filt[a] <= cand[a];
      end
    end
  end

  // FSM state register together with speed and ramp counter.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state <= S_IDLE;
      speed <= 4'd0;
      ramp  <= '0;
    end else begin
      state <= state_n;
      speed <= speed_n;
      ramp  <= ramp_n;
    end
  end

  // Next-state logic: stop, then all-level, then direction change, then the
  // per-state behaviour. Everything reads pre-tick register values.
  always_comb begin
    // NOTE: defaults first so every path assigns every target; no latch.
    state_n = state;
    speed_n = speed;
    ramp_n  = ramp;
    if (tick) begin
      if (stop_r) begin
        state_n = S_HALT;
        speed_n = 4'd0;
        ramp_n  = '0;
      end else if (active && dir == 4'b0000) begin
        state_n = S_IDLE;
        speed_n = 4'd0;
        ramp_n  = '0;
      end else if (active && dir != prev_dir) begin
        state_n = S_ACCEL;
        speed_n = 4'd1;
        ramp_n  = '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (dir != 4'b0000) begin
              state_n = S_ACCEL;
              speed_n = 4'd1;
              ramp_n  = '0;
            end
          end
          S_ACCEL: begin
            if (ramp == RAMP_LAST) begin
              ramp_n  = '0;
              speed_n = speed + 4'd1;
              if (speed + 4'd1 >= SPEED_TOP) begin
                speed_n = SPEED_TOP;
                state_n = S_CRUISE;
              end
            end else begin
              ramp_n = ramp + RAMP_W'(1);
            end
          end
          S_CRUISE: speed_n = SPEED_TOP;
          S_HALT:   state_n = S_IDLE;
          default:  state_n = S_IDLE;
        endcase
      end
    end
  end

  // Output decode of the FSM.
  always_comb begin
    active = (state == S_ACCEL) || (state == S_CRUISE);
    oSPEED = speed;
  end

  assign oMOVING = active;

  // Motion only on a tick that keeps the FSM moving in the same direction:
  // stop, all-level and (re)entry into ACCEL all leave the position alone.
  assign move = tick && active && !stop_r && (dir != 4'b0000) && (dir == prev_dir);

  // Next position with per-axis clamping.
  always_comb begin
    pos_x_n = pos_x;
    pos_y_n = pos_y;
    if (move) begin
      pos_x_n = step_axis(pos_x, filt[0], speed, X_LIM);
      pos_y_n = step_axis(pos_y, filt[1], speed, Y_LIM);
    end
  end

  // Position, edge flags, update pulse and the per-tick direction snapshot.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      pos_x    <= X_HOME;
      pos_y    <= Y_HOME;
      oEDGE    <= 4'b0000;
      oUPDATE  <= 1'b0;
      prev_dir <= 4'b0000;
    end else begin
      pos_x    <= pos_x_n;
      pos_y    <= pos_y_n;
      oEDGE    <= {pos_y_n == Y_LIM, pos_y_n == 10'd0, pos_x_n == X_LIM, pos_x_n == 10'd0};
      oUPDATE  <= (pos_x_n != pos_x) || (pos_y_n != pos_y);
      if (tick) prev_dir <= dir;
    end
  end

  assign oPOS_X = pos_x;
  assign oPOS_Y = pos_y;

endmodule

// File: tb/tb_tilt_motion_tracker.sv
// Bench for tilt_motion_tracker: directed scenarios followed by random tilt /
// stop / reset sequences, all compared every cycle against a behavioural model.
module tb_tilt_motion_tracker;

  localparam int TICK_DIV     = 4;
  localparam int STABLE_TICKS = 2;
  localparam int RAMP_TICKS   = 2;
  localparam int SPEED_MAX    = 3;
  localparam int X_MAX        = 20;
  localparam int Y_MAX        = 10;

  localparam int M_IDLE   = 0;
  localparam int M_ACCEL  = 1;
  localparam int M_CRUISE = 2;
  localparam int M_HALT   = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] dx, dy;
  logic       stop;
  logic [9:0] pos_x, pos_y;
  logic [3:0] speed, edge_o;
  logic       moving, update;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // Reference model state
  int m_rx, m_ry, m_rs, m_tcnt;
  int m_cand [2];
  int m_scnt [2];
  int m_filt [2];
  int m_prev [2];
  int m_state, m_speed, m_ramp, m_px, m_py, m_edge, m_upd;

  always #5 clk = ~clk;

  tilt_motion_tracker #(
    .TICK_DIV(TICK_DIV), .STABLE_TICKS(STABLE_TICKS), .RAMP_TICKS(RAMP_TICKS),
    .SPEED_MAX(SPEED_MAX), .X_MAX(X_MAX), .Y_MAX(Y_MAX)
  ) dut (
    .iCLK(clk), .iRST(rst), .iDATA_X(dx), .iDATA_Y(dy), .iSTOP(stop),
    .oPOS_X(pos_x), .oPOS_Y(pos_y), .oSPEED(speed), .oMOVING(moving),
    .oEDGE(edge_o), .oUPDATE(update)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int code_of(input logic [1:0] c);
    return (c == 2'b11) ? 0 : int'(c);
  endfunction

  function automatic int sign_of(input int c);
    return (c == 1) ? 1 : (c == 2) ? -1 : 0;
  endfunction

  function automatic int clampi(input int v, input int lim);
    if (v < 0)   return 0;
    if (v > lim) return lim;
    return v;
  endfunction

  task automatic model_reset();
    m_rx = 0; m_ry = 0; m_rs = 0; m_tcnt = 0;
    for (int a = 0; a < 2; a++) begin
      m_cand[a] = 0; m_scnt[a] = 0; m_filt[a] = 0; m_prev[a] = 0;
    end
    m_state = M_IDLE; m_speed = 0; m_ramp = 0;
    m_px = X_MAX / 2; m_py = Y_MAX / 2; m_edge = 0; m_upd = 0;
  endtask

  // One clock edge of the specified behaviour, using the inputs at that edge.
  task automatic model_edge();
    bit tick, any_dir, same_dir, was_moving;
    int nx, ny, raw_now;
    if (rst) begin
      model_reset();
      return;
    end
    tick       = (m_tcnt == TICK_DIV - 1);
    any_dir    = (m_filt[0] != 0) || (m_filt[1] != 0);
    same_dir   = (m_filt[0] == m_prev[0]) && (m_filt[1] == m_prev[1]);
    was_moving = (m_state == M_ACCEL) || (m_state == M_CRUISE);
    nx = m_px;
    ny = m_py;
    if (tick) begin
      if (was_moving && !m_rs && any_dir && same_dir) begin
        nx = clampi(m_px + sign_of(m_filt[0]) * m_speed, X_MAX);
        ny = clampi(m_py + sign_of(m_filt[1]) * m_speed, Y_MAX);
      end
      if (m_rs) begin
        m_state = M_HALT; m_speed = 0; m_ramp = 0;
      end else if (was_moving && !any_dir) begin
        m_state = M_IDLE; m_speed = 0; m_ramp = 0;
      end else if (was_moving && !same_dir) begin
        m_state = M_ACCEL; m_speed = 1; m_ramp = 0;
      end else if (m_state == M_IDLE) begin
        if (any_dir) begin
          m_state = M_ACCEL; m_speed = 1; m_ramp = 0;
        end
      end else if (m_state == M_ACCEL) begin
        if (m_ramp == RAMP_TICKS - 1) begin
          m_ramp  = 0;
          m_speed = m_speed + 1;
          if (m_speed >= SPEED_MAX) begin
            m_speed = SPEED_MAX;
            m_state = M_CRUISE;
          end
        end else begin
          m_ramp = m_ramp + 1;
        end
      end else if (m_state == M_HALT) begin
        m_state = M_IDLE;
      end
      m_prev[0] = m_filt[0];
      m_prev[1] = m_filt[1];
    end
    for (int a = 0; a < 2; a++) begin
      raw_now = (a == 0) ? m_rx : m_ry;
      if (raw_now != m_cand[a]) begin
        m_cand[a] = raw_now;
        m_scnt[a] = 0;
      end else if (tick) begin
        if (m_scnt[a] < STABLE_TICKS) m_scnt[a] = m_scnt[a] + 1;
        if (m_scnt[a] == STABLE_TICKS) m_filt[a] = m_cand[a];
      end
    end
    m_rx   = code_of(dx);
    m_ry   = code_of(dy);
    m_rs   = int'(stop);
    m_tcnt = (m_tcnt + 1) % TICK_DIV;
    m_upd  = (nx != m_px || ny != m_py) ? 1 : 0;
    m_px   = nx;
    m_py   = ny;
    m_edge = (m_px == 0 ? 1 : 0) | (m_px == X_MAX ? 2 : 0) |
             (m_py == 0 ? 4 : 0) | (m_py == Y_MAX ? 8 : 0);
  endtask

  // Advance one clock, update the model, then compare away from the edge.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("pos_x",  pos_x,  m_px);
    check("pos_y",  pos_y,  m_py);
    check("speed",  speed,  m_speed);
    check("moving", moving, (m_state == M_ACCEL || m_state == M_CRUISE) ? 1 : 0);
    check("edge",   edge_o, m_edge);
    check("update", update, m_upd);
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  initial begin
    int xs[$];
    int exp_x[6];
    int hold;
    bit saw_move;
    exp_x = '{11, 12, 14, 16, 19, 20};
    model_reset();
    rst = 1'b1; dx = 2'b00; dy = 2'b00; stop = 1'b0;

    // Reset
    run(3);
    check("rst_pos_x", pos_x, 10);
    check("rst_pos_y", pos_y, 5);
    check("rst_speed", speed, 0);
    check("rst_moving", moving, 0);
    check("rst_edge", edge_o, 0);
    check("rst_update", update, 0);

    // Ramp and saturate on +X
    rst = 1'b0; dx = 2'b01;
    for (int i = 0; i < 48; i++) begin
      step();
      if (update === 1'b1) xs.push_back(int'(pos_x));
    end
    check("ramp_update_count", xs.size(), 6);
    for (int i = 0; i < 6; i++)
      check("ramp_x_seq", (i < xs.size()) ? xs[i] : -1, exp_x[i]);
    check("ramp_speed_cruise", speed, 3);
    check("ramp_edge_xmax", edge_o, 4'b0010);
    check("ramp_x_held", pos_x, 20);

    // Stop while cruising, then release
    stop = 1'b1;
    run(12);
    check("halt_speed", speed, 0);
    check("halt_moving", moving, 0);
    check("halt_x", pos_x, 20);
    stop = 1'b0;
    run(4);
    check("halt_to_idle_moving", moving, 0);
    run(8);
    check("reaccel_moving", moving, 1);
    check("reaccel_speed", speed, 1);
    run(16);
    check("recruise_speed", speed, 3);

    // Direction change in cruise: restart at speed 1 heading -X
    dx = 2'b10;
    run(16);
    check("dirchg_speed", speed, 1);
    check("dirchg_x", pos_x, 19);
    run(36);
    check("clamp_x0", pos_x, 0);
    check("clamp_edge_x0", edge_o, 4'b0001);

    // Stop and direction change together: stop wins
    stop = 1'b1; dx = 2'b01;
    run(12);
    check("stop_wins_moving", moving, 0);
    check("stop_wins_speed", speed, 0);
    check("stop_wins_x", pos_x, 0);

    // Glitch rejection from a clean reset
    stop = 1'b0; dx = 2'b00; rst = 1'b1;
    run(1);
    rst = 1'b0; dy = 2'b10;
    run(4);
    dy = 2'b00;
    saw_move = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (moving === 1'b1) saw_move = 1'b1;
    end
    check("glitch_no_move", saw_move, 0);
    check("glitch_pos_x", pos_x, 10);
    check("glitch_pos_y", pos_y, 5);
    dx = 2'b11; dy = 2'b11;
    for (int i = 0; i < 40; i++) begin
      step();
      if (moving === 1'b1) saw_move = 1'b1;
    end
    check("code11_no_move", saw_move, 0);
    check("code11_pos_x", pos_x, 10);
    check("code11_pos_y", pos_y, 5);

    // Reset mid-cruise, then a full debounce before motion resumes
    dx = 2'b01; dy = 2'b01;
    run(60);
    check("diag_cruise_speed", speed, 3);
    rst = 1'b1;
    run(1);
    check("midrst_pos_x", pos_x, 10);
    check("midrst_pos_y", pos_y, 5);
    check("midrst_speed", speed, 0);
    check("midrst_moving", moving, 0);
    check("midrst_edge", edge_o, 0);
    check("midrst_update", update, 0);
    rst = 1'b0;
    run(14);
    check("post_rst_still_x", pos_x, 10);
    run(4);
    check("post_rst_first_x", pos_x, 11);
    check("post_rst_first_y", pos_y, 6);

    // Random tilt / stop / reset sequences
    for (int seg = 0; seg < 60; seg++) begin
      dx   = 2'($urandom_range(0, 3));
      dy   = 2'($urandom_range(0, 3));
      stop = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 29) == 0) begin
        rst = 1'b1;
        run(1);
        rst = 1'b0;
      end
      hold = $urandom_range(1, 40);
      run(hold);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/tilt_motion_tracker.md
# tilt_motion_tracker

Converts the accelerometer controller's per-axis 2-bit tilt codes and stop flag into a debounced, speed-ramped sprite position for the VGA and segment-display stages. Sits directly downstream of the SPI controller and upstream of the display consumers. Every state update occurs on a divided motion tick. Position saturates at the screen limits.

## Interface
- TICK_DIV, 500000: clock cycles per motion tick (10 ms at 50 MHz).
- STABLE_TICKS, 3: consecutive ticks a raw tilt code must hold before it is accepted.
- RAMP_TICKS, 10: ticks spent at each speed before incrementing it.
- SPEED_MAX, 8: cruise speed in pixels/tick; valid range 1..15.
- X_MAX, 624: maximum X position (640 minus 16-pixel sprite).
- Y_MAX, 464: maximum Y position.
- iCLK  in  1  system clock (CLOCK_50 domain). Single clock for the whole block.
- iRST  in  1  reset. Synchronous, active-high (driven from the reset_delay output).
- iDATA_X  in  2  X tilt code: 00 level, 01 positive, 10 negative, 11 treated as level.
- iDATA_Y  in  2  Y tilt code, same encoding as iDATA_X.
- iSTOP  in  1  freeze request from the controller.
- oPOS_X  out  10  sprite X position, 0..X_MAX.
- oPOS_Y  out  10  sprite Y position, 0..Y_MAX.
- oSPEED  out  4  current speed.
- oMOVING  out  1  high when the state is ACCEL or CRUISE.
- oEDGE  out  4  [0] X==0, [1] X==X_MAX, [2] Y==0, [3] Y==Y_MAX.
- oUPDATE  out  1  one-cycle pulse when oPOS_X or oPOS_Y changed value.

## Operation
- Input stage: iDATA_X, iDATA_Y and iSTOP are registered once. Codes of 11 are mapped to 00 at this register.
- Tick counter: counts 0..TICK_DIV-1 and wraps. The tick strobe is high for the cycle in which the count equals TICK_DIV-1.
- Debounce, independent per axis:
  - Each axis holds a candidate code and a stable counter.
  - A registered raw code that differs from the candidate loads the candidate and clears the counter immediately, without waiting for a tick.
  - On each tick where raw equals the candidate, the counter increments, saturating at STABLE_TICKS.
  - When the counter reaches STABLE_TICKS, the filtered direction takes the candidate value.
- On a tick, the FSM and the position logic use the pre-tick register values (state, speed, filtered directions, registered stop).
- FSM states:
  - IDLE: speed is 0. If stop is low and either filtered direction is non-zero, go to ACCEL with speed 1 and ramp counter 0.
  - ACCEL: the ramp counter increments each tick. At RAMP_TICKS-1 it clears and speed increments. If the new speed equals SPEED_MAX, go to CRUISE.
  - CRUISE: speed holds at SPEED_MAX.
  - HALT: speed is 0. Go to IDLE on the first tick with stop low.
- FSM transitions, in priority order:
  1. Stop high in any state: go to HALT with speed 0.
  2. From ACCEL or CRUISE, both filtered directions level: go to IDLE with speed 0.
  3. From ACCEL or CRUISE, filtered direction vector differs from its value at the previous tick: go to ACCEL with speed 1 and ramp counter 0.
- Motion: on a tick whose pre-tick state is ACCEL or CRUISE, each axis updates as pos ± speed (or unchanged if level).
  - Arithmetic is 11-bit signed.
  - Results below 0 clamp to 0. Results above MAX clamp to MAX.
  - HALT, IDLE and the tick on which ACCEL is entered produce no motion.
- oEDGE is registered from the updated position.

## Timing
- Reset values:
  - oPOS_X = X_MAX/2 and oPOS_Y = Y_MAX/2, using truncating division.
  - oSPEED = 0, oMOVING = 0, oUPDATE = 0.
  - oEDGE = 0000, state IDLE, all counters 0, filtered directions 00.
- Reset asserted mid-operation restores all reset values on the next edge. The tick phase restarts from 0.
- Latency from an input change to motion: one cycle for the register, then:
  - the filtered direction updates at the STABLE_TICKS-th tick;
  - the FSM enters ACCEL at the next tick;
  - the first motion occurs at the tick after that.
- Positions, oSPEED, oMOVING and oEDGE are visible the cycle after the tick. oUPDATE is high for that same single cycle.
- A raw glitch shorter than STABLE_TICKS ticks produces no filtered change and no motion.
- Stop takes effect at the first tick after it is registered. No motion occurs at that tick.

## Test plan
Parameters for all scenarios: TICK_DIV=4, STABLE_TICKS=2, RAMP_TICKS=2, SPEED_MAX=3, X_MAX=20, Y_MAX=10.
- Reset: assert iRST for 3 cycles -> pos (10,5), oSPEED 0, oMOVING 0, oEDGE 0000, oUPDATE 0.
- Ramp and saturate: hold iDATA_X=01 -> X values after ticks 4..9 are 11, 12, 14, 16, 19, 20. oSPEED reaches 3 (CRUISE) after tick 7. After tick 9, oEDGE[1]=1 and X stays at 20. oUPDATE pulses exactly 6 times.
- Glitch rejection: iDATA_Y=10 for 1 tick, then 00 -> pos stays (10,5), oMOVING stays 0. Code 11 held for 10 ticks -> no motion.
- Stop: iSTOP=1 while in CRUISE -> next tick state HALT, oSPEED 0, no position change. After release -> IDLE, then ACCEL again at speed 1.
- Direction change: in CRUISE moving +X, switch to iDATA_X=10 -> after filtering, speed resets to 1 and X decreases, clamping at 0 with oEDGE[0]=1. Simultaneous stop and direction change -> HALT wins.
- Reset mid-cruise: assert iRST -> all outputs return to reset values on the next edge. Motion resumes only after a full debounce.
